// File: rtl/pixel_sequencer_ng.sv
// Graphics pixel sequencer: capture, delay, shift (hires / multicolor / packed 4bpp),
// then colour decode, sprite priority mix, border masking and sticky collision flags.
module pixel_sequencer_ng #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned GFX_DELAY   = 2
) (
    input  logic                           clk_dot4x,
    input  logic                           rst,
    input  logic                           dot_rising_0,
    input  logic                           capture,
    input  logic                           cycle_visible,
    input  logic [2:0]                     xpos_mod_8,
    input  logic [2:0]                     xscroll,
    input  logic [2:0]                     gfx_mode,
    input  logic                           ext4bpp,
    input  logic [7:0]                     pixels_read,
    input  logic [11:0]                    char_read,
    input  logic [4*COLOR_W-1:0]           bg_col,
    input  logic [COLOR_W-1:0]             ec,
    input  logic                           main_border,
    input  logic [2*NUM_SPRITES-1:0]       sprite_pix,
    input  logic [NUM_SPRITES-1:0]         sprite_pri,
    input  logic [NUM_SPRITES-1:0]         sprite_mmc,
    input  logic [COLOR_W*NUM_SPRITES-1:0] sprite_col,
    input  logic [2*COLOR_W-1:0]           sprite_mc,
    input  logic                           coll_clr,
    output logic [COLOR_W-1:0]             pixel_color,
    output logic                           is_background,
    output logic [NUM_SPRITES-1:0]         sb_coll,
    output logic [NUM_SPRITES-1:0]         ss_coll
);

    logic [7:0]                  stage0_pix_q, stage0_pix_d;
    logic [11:0]                 stage0_char_q, stage0_char_d;
    logic [2:0]                  xscroll_q, xscroll_d;
    logic [GFX_DELAY:1][7:0]     dl_pix_q, dl_pix_d;
    logic [GFX_DELAY:1][11:0]    dl_char_q, dl_char_d;
    logic [7:0]                  shifter_q, shifter_d;
    logic [11:0]                 char_q, char_d;
    logic [1:0]                  phase_q, phase_d;
    logic [COLOR_W-1:0]          gfx_color_q, gfx_color_d;
    logic                        fg_q, fg_d;
    logic [COLOR_W-1:0]          pixel_color_q, pixel_color_d;
    logic [NUM_SPRITES-1:0]      sb_coll_q, sb_coll_d;
    logic [NUM_SPRITES-1:0]      ss_coll_q, ss_coll_d;

    logic                        ismc;
    logic                        cur_bg;
    logic [COLOR_W-1:0]          color_sel;
    logic [NUM_SPRITES-1:0]      opaque;
    logic                        any_opaque;
    logic                        multi_opaque;
    logic                        win_pri;
    logic [COLOR_W-1:0]          win_col;
    logic [COLOR_W-1:0]          spr_col;
    logic [1:0]                  spix;
    logic [COLOR_W-1:0]          mix_col;

    function automatic logic [COLOR_W-1:0] zx4(input logic [3:0] v);
        logic [COLOR_W-1:0] r;
        r      = '0;
        r[3:0] = v;
        return r;
    endfunction

    function automatic logic [COLOR_W-1:0] bgc(input logic [1:0] i);
        return bg_col[int'(i)*COLOR_W +: COLOR_W];
    endfunction

    assign ismc   = gfx_mode[0] & (gfx_mode[1] | gfx_mode[2] | char_q[11]);
    assign cur_bg = ext4bpp ? (shifter_q[7:4] == 4'd0) : !shifter_q[7];

    // Capture, delay line and shifter
    always_comb begin
        stage0_pix_d  = stage0_pix_q;
        stage0_char_d = stage0_char_q;
        xscroll_d     = xscroll_q;
        dl_pix_d      = dl_pix_q;
        dl_char_d     = dl_char_q;
        shifter_d     = shifter_q;
        char_d        = char_q;
        phase_d       = phase_q;
        if (capture) begin
            stage0_pix_d  = pixels_read;
            stage0_char_d = char_read;
            if (cycle_visible)
                xscroll_d = xscroll;
        end
        if (dot_rising_0) begin
            dl_pix_d[1]  = stage0_pix_q;
            dl_char_d[1] = stage0_char_q;
            for (int unsigned k = 2; k <= GFX_DELAY; k++) begin
                dl_pix_d[k]  = dl_pix_q[k-1];
                dl_char_d[k] = dl_char_q[k-1];
            end
            if (xpos_mod_8 == xscroll_q) begin
                shifter_d = dl_pix_q[GFX_DELAY];
                char_d    = dl_char_q[GFX_DELAY];
                phase_d   = 2'd0;
            end else begin
                phase_d = phase_q + 2'd1;
                if (ext4bpp) begin
                    if (phase_q == 2'd3)
                        shifter_d = {shifter_q[3:0], 4'd0};
                end else if (ismc) begin
                    if (phase_q[0])
                        shifter_d = {shifter_q[5:0], 2'd0};
                end else begin
                    shifter_d = {shifter_q[6:0], 1'b0};
                end
            end
        end
    end

    // Colour decode of the current shifter pixel
    always_comb begin
        color_sel = '0;
        if (ext4bpp) begin
            color_sel = zx4(shifter_q[7:4]);
        end else begin
            case (gfx_mode)
                3'b000: color_sel = shifter_q[7] ? zx4(char_q[11:8]) : bgc(2'd0);
                3'b001: begin
                    if (char_q[11]) begin
                        case (shifter_q[7:6])
                            2'b00:   color_sel = bgc(2'd0);
                            2'b01:   color_sel = bgc(2'd1);
                            2'b10:   color_sel = bgc(2'd2);
                            default: color_sel = zx4({1'b0, char_q[10:8]});
                        endcase
                    end else begin
                        color_sel = shifter_q[7] ? zx4({1'b0, char_q[10:8]}) : bgc(2'd0);
                    end
                end
                3'b010: color_sel = shifter_q[7] ? zx4(char_q[7:4]) : zx4(char_q[3:0]);
                3'b011: begin
                    case (shifter_q[7:6])
                        2'b00:   color_sel = bgc(2'd0);
                        2'b01:   color_sel = zx4(char_q[7:4]);
                        2'b10:   color_sel = zx4(char_q[3:0]);
                        default: color_sel = zx4(char_q[11:8]);
                    endcase
                end
                3'b100: color_sel = shifter_q[7] ? zx4(char_q[11:8]) : bgc(char_q[7:6]);
                default: color_sel = '0;
            endcase
        end
        gfx_color_d = dot_rising_0 ? color_sel : gfx_color_q;
        fg_d        = dot_rising_0 ? !cur_bg : fg_q;
    end

    // Sprite mix, border and collisions; lowest-index opaque sprite decides priority
    always_comb begin
        opaque       = '0;
        any_opaque   = 1'b0;
        multi_opaque = 1'b0;
        win_pri      = 1'b0;
        win_col      = '0;
        spr_col      = '0;
        spix         = 2'd0;
        for (int unsigned n = 0; n < NUM_SPRITES; n++) begin
            spix      = sprite_pix[2*n +: 2];
            opaque[n] = sprite_mmc[n] ? (spix != 2'd0) : spix[1];
            spr_col   = sprite_col[n*COLOR_W +: COLOR_W];
            if (sprite_mmc[n]) begin
                if (spix == 2'b01)
                    spr_col = sprite_mc[COLOR_W-1:0];
                else if (spix == 2'b11)
                    spr_col = sprite_mc[2*COLOR_W-1:COLOR_W];
            end
            if (opaque[n]) begin
                if (any_opaque)
                    multi_opaque = 1'b1;
                else begin
                    win_pri = sprite_pri[n];
                    win_col = spr_col;
                end
                any_opaque = 1'b1;
            end
        end
        if (main_border)
            mix_col = ec;
        else if (any_opaque && !(win_pri && fg_q))
            mix_col = win_col;
        else
            mix_col = gfx_color_q;
        pixel_color_d = dot_rising_0 ? mix_col : pixel_color_q;
        sb_coll_d = coll_clr ? '0 : sb_coll_q;
        ss_coll_d = coll_clr ? '0 : ss_coll_q;
        if (dot_rising_0) begin
            sb_coll_d = sb_coll_d | (opaque & {NUM_SPRITES{fg_q}});
            ss_coll_d = ss_coll_d | (opaque & {NUM_SPRITES{multi_opaque}});
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            stage0_pix_q  <= '0;
            stage0_char_q <= '0;
            xscroll_q     <= '0;
            dl_pix_q      <= '0;
            dl_char_q     <= '0;
            shifter_q     <= '0;
            char_q        <= '0;
            phase_q       <= '0;
            gfx_color_q   <= '0;
            fg_q          <= 1'b0;
            pixel_color_q <= '0;
            sb_coll_q     <= '0;
            ss_coll_q     <= '0;
        end else begin
            stage0_pix_q  <= stage0_pix_d;
            stage0_char_q <= stage0_char_d;
            xscroll_q     <= xscroll_d;
            dl_pix_q      <= dl_pix_d;
            dl_char_q     <= dl_char_d;
            shifter_q     <= shifter_d;
            char_q        <= char_d;
            phase_q       <= phase_d;
            gfx_color_q   <= gfx_color_d;
            fg_q          <= fg_d;
            pixel_color_q <= pixel_color_d;
            sb_coll_q     <= sb_coll_d;
            ss_coll_q     <= ss_coll_d;
        end
    end

    assign pixel_color   = pixel_color_q;
    assign is_background = cur_bg;
    assign sb_coll       = sb_coll_q;
    assign ss_coll       = ss_coll_q;

endmodule

// File: doc/pixel_sequencer_ng.md
Name: pixel_sequencer_ng

Overview:
Parametrised next-generation graphics pixel sequencer: captures fetched pixel/char data, delays it by a configurable dot count, and shifts it out with hires, multicolor and a new packed 4bpp mode. It mixes up to NUM_SPRITES sprites with priority, applies border masking, and adds sticky sprite-background and sprite-sprite collision detection. It sits between the fetch/sprite units and the video output pipeline.

Parameters:
NUM_SPRITES, 8, number of sprite channels (1..16)
COLOR_W, 4, colour index width; 4-bit char/attr colours are zero-extended to COLOR_W
GFX_DELAY, 2, dot ticks between capture and shifter-load availability (1..8)

Ports:
clk_dot4x  in  1  dot x4 clock
rst  in  1  reset: synchronous, active-high; clock clk_dot4x
dot_rising_0  in  1  one-clk enable per dot; all pipeline stages advance only on it
capture  in  1  one-clk strobe at end of PHI low phase; latches pixels_read/char_read
cycle_visible  in  1  xscroll is latched at capture only when high
xpos_mod_8  in  3  dot position within cell
xscroll  in  3  fine horizontal scroll
gfx_mode  in  3  {ecm,bmm,mcm}
ext4bpp  in  1  packed 4bpp mode enable; overrides gfx_mode
pixels_read  in  8  fetched graphics byte
char_read  in  12  fetched {colour[3:0], char/screen[7:0]}
bg_col  in  4*COLOR_W  b0c..b3c, b0c in LSBs
ec  in  COLOR_W  border colour
main_border  in  1  border active for current output dot
sprite_pix  in  2*NUM_SPRITES  current sprite pixel pairs, sprite n at [2n+1:2n]
sprite_pri  in  NUM_SPRITES  1 = sprite n behind foreground
sprite_mmc  in  NUM_SPRITES  1 = sprite n multicolor
sprite_col  in  COLOR_W*NUM_SPRITES  per-sprite colour
sprite_mc  in  2*COLOR_W  {mc1,mc0}
coll_clr  in  1  one-clk clear of both collision registers
pixel_color  out  COLOR_W  final dot colour
is_background  out  1  current shifter pixel is background
sb_coll  out  NUM_SPRITES  sticky sprite-background collision
ss_coll  out  NUM_SPRITES  sticky sprite-sprite collision

Behaviour:
- Reset: pixel_color=0, is_background=1, sb_coll=0, ss_coll=0, shifter/char regs/delay line/xscroll_q=0, shift phase=0. Reset mid-line wins over all enables; output is 0 until data is reloaded.
- Capture: on capture, stage0 <= pixels_read/char_read; xscroll_q <= xscroll if cycle_visible. Each dot tick shifts the delay line; tap GFX_DELAY feeds load.
- Load when xpos_mod_8==xscroll_q on a dot tick: shifter <= tap byte, char_q <= tap char, phase counter <= 0.
- ismc = mcm & (bmm|ecm|char_q[11]). Hires: shift 1 bit every dot. MC: shift 2 bits every 2nd dot (first pair held 2 dots after load). 4bpp: nibble [7:4] for 4 dots, then [3:0] for 4 dots; shift 4 bits on phase==3.
- is_background = !MSB of the current pixel (MC: !bit7 of pair; 4bpp: nibble==0); updated on the same tick as the shifter.
- Colour stage (+1 dot): standard/MC/bitmap/ECM decoding as in the current VIC-II modes; illegal modes (ecm with bmm or mcm) give 0; 4bpp gives nibble zero-extended.
- Mix+border stage (+2 dots): sprite opaque = mmc ? pix!=0 : pix[1]; MC 01->mc0, 10->sprite_col, 11->mc1. Winner = lowest-index opaque sprite. If winner pri=1 and foreground: gfx colour (a higher-priority behind-sprite masks lower front sprites). Else winner colour. If main_border: ec. Total latency load->pixel_color = 2 dot ticks.
- Collisions (mix stage, evaluated under border too): sb_coll[n] |= opaque[n] & foreground; ss_coll[n] |= opaque[n] & (>=2 opaque). coll_clr clears; same-tick clr and set leaves bit set.
- Parameter widths: all packed buses indexed exactly as listed; no truncation when COLOR_W>4.

Test Plan:
- Hires: gfx_mode=000, xscroll=0, byte A5, char colour 7, b0c=6 -> pixel_color sequence 7,6,7,6,6,7,6,7 starting 2 dots after load.
- xscroll=3: same byte -> first pixel appears 3 dots later; xscroll change with cycle_visible=0 ignored.
- MC char 001, char[11]=1, byte 1B, b1c=2, b2c=3, colour 5 (char[11:8]=D) -> 6,6,2,2,3,3,5,5.
- ext4bpp=1, byte 3C -> four dots of 3, four of C; is_background=0 throughout; byte 0F -> first four dots is_background=1.
- Sprites 0 (pri=1, hires) and 2 (pri=0) opaque over foreground -> gfx colour shown; sb_coll=0000_0101, ss_coll=0000_0101; coll_clr -> 0.
- main_border=1 with opaque sprite -> pixel_color=ec; rst asserted mid-line -> next clk outputs 0, collisions 0.
